// File: rtl/hazard3_rr_arbiter.sv
// Round-robin arbiter with one-hot grant, hold-until-ready and optional owner lock.
// Priority rotates past the last accepted winner; grant is combinational from state and req.
module hazard3_rr_arbiter #(
    parameter int W_REQ        = 4,
    parameter int HIGHEST_WINS = 0,
    parameter int ENABLE_LOCK  = 1,
    parameter int W_IDX        = $clog2(W_REQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [W_REQ-1:0] req,
    input  logic             lock,
    input  logic             gnt_ready,
    output logic [W_REQ-1:0] gnt,
    output logic [W_IDX-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             locked
);

    // Reset seeds last_gnt so the first free grant lands on the end opposite the seed.
    localparam logic [W_REQ-1:0] LAST_RESET = (HIGHEST_WINS != 0) ?
        W_REQ'(1) : {1'b1, {(W_REQ-1){1'b0}}};

    logic [W_REQ-1:0] last_gnt;
    logic [W_REQ-1:0] held_gnt;
    logic             held;
    logic             locked_q;

    logic [W_REQ-1:0] above;
    logic [W_REQ-1:0] below;
    logic [W_REQ-1:0] cand;
    logic [W_REQ-1:0] pool;
    logic [W_REQ-1:0] free_gnt;
    logic [W_REQ-1:0] gnt_int;
    int               last_idx;

    always_comb begin
        last_idx = 0;
        for (int i = 0; i < W_REQ; i++) begin
            if (last_gnt[i]) last_idx = i;
        end
    end

    // Prefer requesters past the last winner in rotation order, else wrap to the full request set.
    always_comb begin
        above = '0;
        below = '0;
        for (int i = 0; i < W_REQ; i++) begin
            above[i] = (i > last_idx);
            below[i] = (i < last_idx);
        end
        cand     = (HIGHEST_WINS != 0) ? (req & below) : (req & above);
        pool     = (|cand) ? cand : req;
        free_gnt = '0;
        if (HIGHEST_WINS != 0) begin
            for (int i = 0; i < W_REQ; i++) begin
                if (pool[i]) free_gnt = W_REQ'(1) << i;
            end
        end else begin
            for (int i = W_REQ - 1; i >= 0; i--) begin
                if (pool[i]) free_gnt = W_REQ'(1) << i;
            end
        end
    end

    always_comb begin
        if (!rst_n)        gnt_int = '0;
        else if (locked_q) gnt_int = req & last_gnt;
        else if (held)     gnt_int = req & held_gnt;
        else               gnt_int = free_gnt;
    end

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < W_REQ; i++) begin
            if (gnt_int[i]) gnt_idx = gnt_idx | W_IDX'(i);
        end
    end

    assign gnt       = gnt_int;
    assign gnt_valid = |gnt_int;
    assign locked    = locked_q & rst_n;

    // An empty grant means the owner dropped its request, which releases both hold and lock.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_gnt <= LAST_RESET;
            held     <= 1'b0;
            held_gnt <= '0;
            locked_q <= 1'b0;
        end else if (gnt_valid) begin
            if (gnt_ready) begin
                last_gnt <= gnt_int;
                held     <= 1'b0;
                locked_q <= lock && (ENABLE_LOCK != 0);
            end else begin
                held     <= 1'b1;
                held_gnt <= gnt_int;
            end
        end else begin
            held     <= 1'b0;
            locked_q <= 1'b0;
        end
    end

    gnt_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt_int));
    gnt_subset:  assert property (@(posedge clk) disable iff (!rst_n) (gnt_int & ~req) == '0);
    last_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot(last_gnt));

endmodule

// File: tb/tb_hazard3_rr_arbiter.sv
// Directed bench for hazard3_rr_arbiter: default, lock-disabled and descending-priority instances.
module tb_hazard3_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic       lock = 1'b0;
    logic       gnt_ready = 1'b0;

    logic [3:0] gnt_a, gnt_b, gnt_c;
    logic [1:0] idx_a, idx_b, idx_c;
    logic       valid_a, valid_b, valid_c;
    logic       locked_a, locked_b, locked_c;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    hazard3_rr_arbiter #(.W_REQ(4), .HIGHEST_WINS(0), .ENABLE_LOCK(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .req(req), .lock(lock), .gnt_ready(gnt_ready),
        .gnt(gnt_a), .gnt_idx(idx_a), .gnt_valid(valid_a), .locked(locked_a)
    );

    hazard3_rr_arbiter #(.W_REQ(4), .HIGHEST_WINS(0), .ENABLE_LOCK(0)) u_nolock (
        .clk(clk), .rst_n(rst_n), .req(req), .lock(lock), .gnt_ready(gnt_ready),
        .gnt(gnt_b), .gnt_idx(idx_b), .gnt_valid(valid_b), .locked(locked_b)
    );

    hazard3_rr_arbiter #(.W_REQ(4), .HIGHEST_WINS(1), .ENABLE_LOCK(1)) u_mirror (
        .clk(clk), .rst_n(rst_n), .req(req), .lock(lock), .gnt_ready(gnt_ready),
        .gnt(gnt_c), .gnt_idx(idx_c), .gnt_valid(valid_c), .locked(locked_c)
    );

    // Inputs change 1 time unit after each rising edge; checks run 1 unit later.
    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        req = 4'b0000;
        lock = 1'b0;
        gnt_ready = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        req = 4'b1111;
        lock = 1'b1;
        gnt_ready = 1'b1;
        cyc();
        cyc();
        #1;
        tests++;
        if (gnt_a !== 4'b0000 || valid_a !== 1'b0 || idx_a !== 2'd0 || locked_a !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_outputs: gnt=%b valid=%b idx=%0d locked=%b, expected all zero",
                     gnt_a, valid_a, idx_a, locked_a);
        end
        tests++;
        if (gnt_c !== 4'b0000 || valid_c !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_mirror: gnt=%b valid=%b, expected 0000 0", gnt_c, valid_c);
        end
        req = 4'b0000;
        lock = 1'b0;
        gnt_ready = 1'b0;
        rst_n = 1'b1;
        #1;
        tests++;
        if (locked_a !== 1'b0 || valid_a !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_release: locked=%b valid=%b, expected 0 0", locked_a, valid_a);
        end
        cyc();
    endtask

    task automatic test_fairness;
        logic [3:0] exp_gnt [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [1:0] exp_idx [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        req = 4'b1111;
        gnt_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            tests++;
            if (gnt_a !== exp_gnt[i] || idx_a !== exp_idx[i] || valid_a !== 1'b1) begin
                fails++;
                $display("[TB] FAIL fairness[%0d]: gnt=%b idx=%0d valid=%b, expected %b %0d 1",
                         i, gnt_a, idx_a, valid_a, exp_gnt[i], exp_idx[i]);
            end
            cyc();
        end
    endtask

    task automatic test_backpressure;
        do_reset();
        req = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            gnt_ready = (i == 3);
            #1;
            tests++;
            if (gnt_a !== 4'b0001) begin
                fails++;
                $display("[TB] FAIL hold[%0d]: gnt=%b, expected 0001", i, gnt_a);
            end
            cyc();
        end
        gnt_ready = 1'b0;
        #1;
        tests++;
        if (gnt_a !== 4'b0100 || idx_a !== 2'd2) begin
            fails++;
            $display("[TB] FAIL hold_rotate: gnt=%b idx=%0d, expected 0100 2", gnt_a, idx_a);
        end
        cyc();
    endtask

    task automatic test_sparse_wrap;
        do_reset();
        req = 4'b1000;
        gnt_ready = 1'b1;
        cyc();
        req = 4'b0110;
        #1;
        tests++;
        if (gnt_a !== 4'b0010) begin
            fails++;
            $display("[TB] FAIL sparse_wrap: gnt=%b, expected 0010", gnt_a);
        end
        cyc();
        req = 4'b0001;
        #1;
        tests++;
        if (gnt_a !== 4'b0001 || idx_a !== 2'd0) begin
            fails++;
            $display("[TB] FAIL sparse_low: gnt=%b idx=%0d, expected 0001 0", gnt_a, idx_a);
        end
        cyc();
    endtask

    task automatic test_lock;
        logic [3:0] exp_b;
        do_reset();
        req = 4'b0011;
        lock = 1'b1;
        gnt_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 3) lock = 1'b0;
            exp_b = (i % 2 == 1) ? 4'b0010 : 4'b0001;
            #1;
            if (i < 4) begin
                tests++;
                if (gnt_a !== 4'b0001 || locked_a !== (i > 0)) begin
                    fails++;
                    $display("[TB] FAIL lock[%0d]: gnt=%b locked=%b, expected 0001 %b",
                             i, gnt_a, locked_a, (i > 0));
                end
            end else begin
                tests++;
                if (gnt_a !== 4'b0010 || locked_a !== 1'b0) begin
                    fails++;
                    $display("[TB] FAIL unlock: gnt=%b locked=%b, expected 0010 0", gnt_a, locked_a);
                end
            end
            tests++;
            if (gnt_b !== exp_b || locked_b !== 1'b0) begin
                fails++;
                $display("[TB] FAIL nolock[%0d]: gnt=%b locked=%b, expected %b 0",
                         i, gnt_b, locked_b, exp_b);
            end
            cyc();
        end
        lock = 1'b0;
    endtask

    task automatic test_abandoned_lock;
        do_reset();
        req = 4'b0100;
        lock = 1'b1;
        gnt_ready = 1'b1;
        cyc();
        lock = 1'b0;
        gnt_ready = 1'b0;
        req = 4'b1001;
        #1;
        tests++;
        if (gnt_a !== 4'b0000 || valid_a !== 1'b0 || locked_a !== 1'b1) begin
            fails++;
            $display("[TB] FAIL abandon_lock: gnt=%b valid=%b locked=%b, expected 0000 0 1",
                     gnt_a, valid_a, locked_a);
        end
        cyc();
        tests++;
        if (gnt_a !== 4'b1000 || locked_a !== 1'b0) begin
            fails++;
            $display("[TB] FAIL abandon_release: gnt=%b locked=%b, expected 1000 0", gnt_a, locked_a);
        end
        cyc();
    endtask

    task automatic test_dropped_hold;
        do_reset();
        req = 4'b0010;
        gnt_ready = 1'b0;
        cyc();
        req = 4'b0011;
        #1;
        tests++;
        if (gnt_a !== 4'b0010) begin
            fails++;
            $display("[TB] FAIL hold_no_preempt: gnt=%b, expected 0010", gnt_a);
        end
        cyc();
        req = 4'b0001;
        #1;
        tests++;
        if (gnt_a !== 4'b0000) begin
            fails++;
            $display("[TB] FAIL hold_drop: gnt=%b, expected 0000", gnt_a);
        end
        cyc();
        tests++;
        if (gnt_a !== 4'b0001) begin
            fails++;
            $display("[TB] FAIL hold_recover: gnt=%b, expected 0001", gnt_a);
        end
        cyc();
    endtask

    task automatic test_mid_reset;
        do_reset();
        req = 4'b0100;
        lock = 1'b1;
        gnt_ready = 1'b1;
        cyc();
        gnt_ready = 1'b0;
        cyc();
        tests++;
        if (gnt_a !== 4'b0100 || locked_a !== 1'b1) begin
            fails++;
            $display("[TB] FAIL midreset_setup: gnt=%b locked=%b, expected 0100 1", gnt_a, locked_a);
        end
        rst_n = 1'b0;
        req = 4'b1111;
        lock = 1'b0;
        cyc();
        tests++;
        if (gnt_a !== 4'b0000 || idx_a !== 2'd0 || valid_a !== 1'b0 || locked_a !== 1'b0) begin
            fails++;
            $display("[TB] FAIL midreset_zero: gnt=%b idx=%0d valid=%b locked=%b, expected all zero",
                     gnt_a, idx_a, valid_a, locked_a);
        end
        rst_n = 1'b1;
        #1;
        tests++;
        if (gnt_a !== 4'b0001 || locked_a !== 1'b0) begin
            fails++;
            $display("[TB] FAIL midreset_first: gnt=%b locked=%b, expected 0001 0", gnt_a, locked_a);
        end
        cyc();
    endtask

    task automatic test_mirror;
        logic [3:0] exp_gnt [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
        logic [1:0] exp_idx [4] = '{2'd3, 2'd2, 2'd1, 2'd0};
        do_reset();
        req = 4'b1111;
        gnt_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            tests++;
            if (gnt_c !== exp_gnt[i] || idx_c !== exp_idx[i] || locked_c !== 1'b0) begin
                fails++;
                $display("[TB] FAIL mirror[%0d]: gnt=%b idx=%0d locked=%b, expected %b %0d 0",
                         i, gnt_c, idx_c, locked_c, exp_gnt[i], exp_idx[i]);
            end
            cyc();
        end
    endtask

    initial begin
        test_reset();
        test_fairness();
        test_backpressure();
        test_sparse_wrap();
        test_lock();
        test_abandoned_lock();
        test_dropped_hold();
        test_mid_reset();
        test_mirror();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hazard3_rr_arbiter.md
Name: hazard3_rr_arbiter

Overview:
Parametrised round-robin arbiter. It is the sequential successor to the one-hot static priority encoder. It takes a request bitmap and produces a one-hot grant. The grant is held stable until a downstream ready handshake completes, and priority then rotates past the last accepted winner. An optional lock lets the current owner keep the grant across back-to-back transfers, for example locked or burst bus sequences. Used in front of shared bus ports, such as multi-master AHB splitters and debug/core access muxes.

Parameters:
W_REQ, 4, number of requesters; legal range 2 to 32.
HIGHEST_WINS, 0, rotation direction: 0 = ascending index order after last winner; 1 = descending.
ENABLE_LOCK, 1, 1 = lock input honoured; 0 = lock ignored, locked output tied 0.
W_IDX, $clog2(W_REQ), width of gnt_idx; derived, not to be overridden.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst_n  in  1  synchronous reset, active low.
req  in  W_REQ  request bitmap; bit i = requester i wants access.
lock  in  1  sampled on an accepted transfer; 1 = owner retains grant afterwards.
gnt_ready  in  1  downstream accepts the currently granted transfer this cycle.
gnt  out  W_REQ  one-hot grant, or all-zero.
gnt_idx  out  W_IDX  binary index of the set bit of gnt; 0 when gnt is zero.
gnt_valid  out  1  OR-reduction of gnt.
locked  out  1  arbiter is locked to last_gnt owner.

Behaviour:
- State registers:
  - last_gnt (W_REQ, one-hot)
  - held (1 bit)
  - held_gnt (W_REQ)
  - locked (1 bit)
- Reset (rst_n low at a clock edge) sets:
  - held = 0, held_gnt = 0, locked = 0
  - last_gnt = bit W_REQ-1 when HIGHEST_WINS = 0, so requester 0 wins first from reset.
  - last_gnt = bit 0 when HIGHEST_WINS = 1, so requester W_REQ-1 wins first from reset.
- gnt, gnt_idx and gnt_valid are combinational from state and req. There is zero-cycle latency from req to gnt when the arbiter is free. All outputs are 0 while rst_n is low.
- Free arbitration (not held, not locked):
  - HIGHEST_WINS = 0: candidates are req bits at indices strictly above the last_gnt index. If any exist, the lowest-indexed one wins. Otherwise the lowest-indexed set bit of req wins (wrap-around).
  - HIGHEST_WINS = 1: mirror image of the above.
  - req = 0 gives gnt = 0.
- Hold:
  - If gnt_valid = 1 and gnt_ready = 0, then held <= 1 and held_gnt <= gnt at the next edge.
  - While held, gnt = held_gnt & req. Other requests, including ones with higher rotated priority, cannot preempt.
  - If the held requester drops req, gnt falls to 0 that cycle and held clears at the next edge. Requesters are required not to do this; the arbiter still recovers cleanly.
- Accept: a cycle with gnt_valid = 1 and gnt_ready = 1 does all of the following at the edge:
  - last_gnt <= gnt
  - held <= 0
  - locked <= lock && ENABLE_LOCK
- gnt_ready while gnt_valid = 0 has no effect.
- Lock:
  - While locked, gnt = req & last_gnt. All other requests are ignored even if the owner is idle.
  - locked clears on an accepted transfer with lock = 0.
  - locked also clears at the edge of any cycle in which the owner's req bit is 0. This is the abandoned-lock recovery path. Other requesters may win in the cycle after that edge.
  - Hold and lock can coexist; the held grant is always the lock owner's.
- gnt_idx: binary encode of gnt. It is defined only for one-hot gnt, which is always the case by construction.
- Invariants, asserted in formal/sim:
  - popcount(gnt) <= 1
  - gnt is a subset of req
  - last_gnt is always one-hot
- Fairness: with all requesters continuously requesting and gnt_ready = 1, lock = 0, each requester is granted exactly once in every W_REQ consecutive accepts.

Test Plan:
- Reset fairness: W_REQ = 4, HIGHEST_WINS = 0, req = 4'b1111, gnt_ready = 1 every cycle from the first cycle out of reset -> gnt sequence 0001, 0010, 0100, 1000, 0001; gnt_idx 0, 1, 2, 3, 0.
- Backpressure hold: req = 4'b0101, gnt_ready = 0 for 3 cycles, then 1 -> gnt = 0001 for all 4 cycles. Next cycle gnt = 0100, last_gnt = 0001.
- Sparse wrap: last accepted = 3, req = 4'b0110 -> gnt = 0010. Accept, then req = 4'b0001 -> gnt = 0001.
- Lock: req = 4'b0011, lock = 1, ready = 1 -> gnt = 0001 on 3 consecutive accepts with locked = 1. Then lock = 0 accept -> locked = 0 and next gnt = 0010. With ENABLE_LOCK = 0 the same stimulus gives alternating 0001 / 0010.
- Abandoned lock and dropped hold: locked to requester 2, req[2] -> 0 with req = 4'b1001 -> gnt = 0 that cycle, locked = 0 next cycle, then gnt = 1000. Separately, held grant 0010 with req[1] dropped -> gnt = 0 immediately and held clears next edge.
- Mid-operation reset and mirror mode: rst_n low during held/locked state -> next cycle all outputs 0, and first grant with req = 1111 is 0001. Repeat with HIGHEST_WINS = 1 -> 1000, 0100, 0010, 0001.
